// File: rtl/dmem_arbiter_pkg.sv
// Shared widths, owner encoding and small helpers for the data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int WORD_LEN = 32;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_UART = 2'd2
  } owner_e;

  function automatic logic [WORD_LEN-1:0] sel_word(input logic en, input logic [WORD_LEN-1:0] w);
    return en ? w : {WORD_LEN{1'b0}};
  endfunction

endpackage

// File: rtl/dmem_rd_tracker.sv
// Per-port read-pending flags: a granted read returns data on the following cycle,
// steered to the port that issued it; the other port sees zero.
module dmem_rd_tracker
  import dmem_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                core_rd_start,
  input  logic                uart_rd_start,
  input  logic [WORD_LEN-1:0] mem_rdata,
  output logic                core_rvalid,
  output logic                uart_rvalid,
  output logic [WORD_LEN-1:0] core_rdata,
  output logic [WORD_LEN-1:0] uart_rdata
);

  logic core_pend_q, core_pend_d;
  logic uart_pend_q, uart_pend_d;

  // A read granted this cycle is pending for exactly the next cycle.
  always_comb begin
    core_pend_d = core_rd_start;
    uart_pend_d = uart_rd_start;
  end

  // Pending flags; reset discards any in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_pend_q <= 1'b0;
      uart_pend_q <= 1'b0;
    end else begin
      core_pend_q <= core_pend_d;
      uart_pend_q <= uart_pend_d;
    end
  end

  // Memory data is presented only to the port whose read is completing.
  always_comb begin
    core_rdata = sel_word(core_pend_q, mem_rdata);
    uart_rdata = sel_word(uart_pend_q, mem_rdata);
  end

  assign core_rvalid = core_pend_q;
  assign uart_rvalid = uart_pend_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (core/UART) arbiter onto a single data-memory port. The UART wins
// contention until it has taken BURST_MAX grants while the core waited.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                core_req,
  input  logic                core_wen,
  input  logic [WORD_LEN-1:0] core_addr,
  input  logic [WORD_LEN-1:0] core_wdata,
  output logic                core_gnt,
  output logic                core_rvalid,
  output logic [WORD_LEN-1:0] core_rdata,
  input  logic                uart_req,
  input  logic                uart_wen,
  input  logic [WORD_LEN-1:0] uart_addr,
  input  logic [WORD_LEN-1:0] uart_wdata,
  output logic                uart_gnt,
  output logic                uart_rvalid,
  output logic [WORD_LEN-1:0] uart_rdata,
  output logic                mem_wen,
  output logic [WORD_LEN-1:0] mem_addr,
  output logic [WORD_LEN-1:0] mem_wdata,
  input  logic [WORD_LEN-1:0] mem_rdata,
  output logic [1:0]          owner
);

  localparam int CNT_W = (BURST_MAX < 8) ? 3 : $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  owner_e           state_q, state_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic             run_q, run_d;
  logic             core_gnt_s, uart_gnt_s;

  // Grant decision; run_q holds grants off until the first edge after reset release.
  always_comb begin
    core_gnt_s = 1'b0;
    uart_gnt_s = 1'b0;
    if (run_q) begin
      uart_gnt_s = uart_req && !(core_req && (burst_q == BURST_LIM));
      core_gnt_s = core_req && !uart_gnt_s;
    end else begin
      core_gnt_s = 1'b0;
      uart_gnt_s = 1'b0;
    end
  end

  // Next owner and starvation counter (counts UART wins only while the core waits).
  always_comb begin
    run_d   = 1'b1;
    burst_d = burst_q;
    if (core_gnt_s) begin
      state_d = OWN_CORE;
    end else if (uart_gnt_s) begin
      state_d = OWN_UART;
    end else begin
      state_d = OWN_IDLE;
    end
    if (core_gnt_s || !core_req) begin
      burst_d = CNT_ZERO;
    end else if (uart_gnt_s && (burst_q != BURST_LIM)) begin
      burst_d = burst_q + CNT_ONE;
    end else begin
      burst_d = burst_q;
    end
  end

  // Owner FSM, counter and run flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OWN_IDLE;
      burst_q <= CNT_ZERO;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      run_q   <= run_d;
    end
  end

  // Memory port follows the granted requester; idle port is driven to zero.
  always_comb begin
    case ({core_gnt_s, uart_gnt_s})
      2'b10: begin
        mem_wen   = core_wen;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
      end
      2'b01: begin
        mem_wen   = uart_wen;
        mem_addr  = uart_addr;
        mem_wdata = uart_wdata;
      end
      default: begin
        mem_wen   = 1'b0;
        mem_addr  = {WORD_LEN{1'b0}};
        mem_wdata = {WORD_LEN{1'b0}};
      end
    endcase
  end

  assign core_gnt = core_gnt_s;
  assign uart_gnt = uart_gnt_s;
  assign owner    = state_q;

  dmem_rd_tracker u_rd_tracker (
    .clk           (clk),
    .rst_n         (rst_n),
    .core_rd_start (core_gnt_s && !core_wen),
    .uart_rd_start (uart_gnt_s && !uart_wen),
    .mem_rdata     (mem_rdata),
    .core_rvalid   (core_rvalid),
    .uart_rvalid   (uart_rvalid),
    .core_rdata    (core_rdata),
    .uart_rdata    (uart_rdata)
  );

endmodule
